// File: rtl/tpuv1_host_seq_if.sv
// rtl/tpuv1_host_seq_if.sv - control, operand/result streams and TPU MMIO bus of tpuv1_host_seq
interface tpuv1_host_seq_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 64
);
  logic             start;
  logic             cfg_load_c;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic             busy;
  logic             done;
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  modport master (
    input  start, cfg_load_c, in_valid, in_data, out_ready, tpu_rdata,
    output in_ready, out_valid, out_data, busy, done, tpu_r_w, tpu_addr, tpu_wdata
  );

  modport slave (
    output start, cfg_load_c, in_valid, in_data, out_ready, tpu_rdata,
    input  in_ready, out_valid, out_data, busy, done, tpu_r_w, tpu_addr, tpu_wdata
  );
endinterface

// File: rtl/tpuv1_host_seq.sv
// rtl/tpuv1_host_seq.sv - MMIO initiator: writes A/B/C into tpuv1, triggers MatMul, streams the C result back
module tpuv1_host_seq #(
  parameter int DIM      = 8,
  parameter int BITS_C   = 16,
  parameter int ADDRW    = 16,
  parameter int DATAW    = 64,
  parameter int MUL_WAIT = 3 * DIM
) (
  input  logic             clk,
  input  logic             rst_n,
  tpuv1_host_seq_if.master host
);

  localparam int CW   = DIM * DIM * BITS_C / DATAW;
  localparam int CNTW = 16;

  localparam logic [ADDRW-1:0] A_BASE  = ADDRW'('h0100);
  localparam logic [ADDRW-1:0] B_BASE  = ADDRW'('h0200);
  localparam logic [ADDRW-1:0] C_BASE  = ADDRW'('h0300);
  localparam logic [ADDRW-1:0] MM_ADDR = ADDRW'('h0400);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A, S_WR_B, S_WR_C, S_GO, S_WAIT, S_RD_ADDR, S_RD_OUT, S_DONE
  } state_t;

  state_t           state_q;
  logic             load_c_q;
  logic [CNTW-1:0]  idx_q;
  logic [CNTW-1:0]  wait_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [DATAW-1:0] out_data_q;
  logic             busy_q;
  logic             done_q;
  logic             r_w_q;
  logic [ADDRW-1:0] addr_q;
  logic [DATAW-1:0] wdata_q;

  logic [ADDRW-1:0] wr_base;
  logic [CNTW-1:0]  wr_last;

  // Every window is word-addressed at 8-byte stride; C reads reuse the C write map.
  function automatic logic [ADDRW-1:0] word_addr(input logic [ADDRW-1:0] base,
                                                 input logic [CNTW-1:0]  idx);
    return base + ADDRW'({idx, 3'b000});
  endfunction

  always_comb begin
    wr_base = A_BASE;
    wr_last = CNTW'(DIM - 1);
    case (state_q)
      S_WR_B:  wr_base = B_BASE;
      S_WR_C: begin
        wr_base = C_BASE;
        wr_last = CNTW'(CW - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      load_c_q    <= 1'b0;
      idx_q       <= '0;
      wait_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      r_w_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      // Bus falls back to neutral unless a state below issues an access.
      r_w_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (host.start) begin
            load_c_q   <= host.cfg_load_c;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_WR_A;
          end
        end
        S_WR_A, S_WR_B, S_WR_C: begin
          if (host.in_valid && in_ready_q) begin
            r_w_q   <= 1'b1;
            addr_q  <= word_addr(wr_base, idx_q);
            wdata_q <= host.in_data;
            if (idx_q == wr_last) begin
              idx_q <= '0;
              if (state_q == S_WR_A) begin
                state_q <= S_WR_B;
              end else if (state_q == S_WR_B && load_c_q) begin
                state_q <= S_WR_C;
              end else begin
                in_ready_q <= 1'b0;
                state_q    <= S_GO;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_GO: begin
          r_w_q   <= 1'b1;
          addr_q  <= MM_ADDR;
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // MUL_WAIT neutral cycles separate the trigger from the first read address.
          if (wait_q == CNTW'(MUL_WAIT)) begin
            idx_q   <= '0;
            addr_q  <= word_addr(C_BASE, '0);
            state_q <= S_RD_ADDR;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_RD_ADDR: begin
          out_data_q  <= host.tpu_rdata;
          out_valid_q <= 1'b1;
          state_q     <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (host.out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == CNTW'(CW - 1)) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              addr_q  <= word_addr(C_BASE, idx_q + 1'b1);
              state_q <= S_RD_ADDR;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign host.in_ready  = in_ready_q;
  assign host.out_valid = out_valid_q;
  assign host.out_data  = out_data_q;
  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign host.tpu_r_w   = r_w_q;
  assign host.tpu_addr  = addr_q;
  assign host.tpu_wdata = wdata_q;

endmodule

// File: tb/tb_tpuv1_host_seq.sv
// tb/tb_tpuv1_host_seq.sv - self-checking bench for tpuv1_host_seq with a behavioural tpuv1 slave
module tb_tpuv1_host_seq;
  localparam int DIM      = 8;
  localparam int CW       = 16;
  localparam int MUL_WAIT = 3 * DIM;
  localparam int ADDRW    = 16;
  localparam int DATAW    = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tpuv1_host_seq_if #(.ADDRW(ADDRW), .DATAW(DATAW)) hif ();

  tpuv1_host_seq #(
    .DIM(DIM), .BITS_C(16), .ADDRW(ADDRW), .DATAW(DATAW), .MUL_WAIT(MUL_WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .host (hif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Behavioural tpuv1 slave: A/B rows of 8-bit elements, C rows of 16-bit elements, C += A*B on trigger.
  logic [7:0]  a_mem [DIM][DIM];
  logic [7:0]  b_mem [DIM][DIM];
  logic [15:0] c_mem [DIM][DIM];
  logic [63:0] c_cache;
  logic [63:0] rdata_c;

  function automatic logic [15:0] dot(input int r, input int c);
    logic [15:0] s;
    s = '0;
    for (int m = 0; m < DIM; m++) s = s + 16'(a_mem[r][m]) * 16'(b_mem[m][c]);
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
          c_mem[r][c] <= '0;
        end
      c_cache <= '0;
    end else if (hif.tpu_r_w) begin
      if (hif.tpu_addr[15:8] == 8'h01 && hif.tpu_addr[7:6] == 2'b00 && hif.tpu_addr[2:0] == 3'b000)
        for (int e = 0; e < DIM; e++) a_mem[hif.tpu_addr[5:3]][e] <= hif.tpu_wdata[8*e +: 8];
      if (hif.tpu_addr[15:8] == 8'h02 && hif.tpu_addr[7:6] == 2'b00 && hif.tpu_addr[2:0] == 3'b000)
        for (int e = 0; e < DIM; e++) b_mem[hif.tpu_addr[5:3]][e] <= hif.tpu_wdata[8*e +: 8];
      if (hif.tpu_addr[15:8] == 8'h03 && !hif.tpu_addr[7] && hif.tpu_addr[2:0] == 3'b000) begin
        if (!hif.tpu_addr[3]) c_cache <= hif.tpu_wdata;
        else
          for (int e = 0; e < 4; e++) begin
            c_mem[hif.tpu_addr[6:4]][e]     <= c_cache[16*e +: 16];
            c_mem[hif.tpu_addr[6:4]][e + 4] <= hif.tpu_wdata[16*e +: 16];
          end
      end
      if (hif.tpu_addr == 16'h0400)
        for (int r = 0; r < DIM; r++)
          for (int c = 0; c < DIM; c++) c_mem[r][c] <= c_mem[r][c] + dot(r, c);
    end
  end

  always_comb begin
    rdata_c = '0;
    if (hif.tpu_addr[15:8] == 8'h03 && !hif.tpu_addr[7])
      for (int e = 0; e < 4; e++)
        rdata_c[16*e +: 16] = c_mem[hif.tpu_addr[6:4]][{hif.tpu_addr[3], 2'(e)}];
  end
  assign hif.tpu_rdata = rdata_c;

  // Mid-cycle monitor: bus log, delivered words, done pulses, out_data hold stability.
  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [63:0] wdata;
  } bus_t;
  bus_t        bus_q[$];
  logic [63:0] got_q[$];
  int          done_cnt = 0;
  int          stab_err = 0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      bus_q.push_back({hif.tpu_r_w, hif.tpu_addr, hif.tpu_wdata});
      if (hif.out_valid && hif.out_ready) got_q.push_back(hif.out_data);
      if (hif.done) done_cnt <= done_cnt + 1;
      if (prev_hold && hif.out_valid && hif.out_data !== prev_data) stab_err <= stab_err + 1;
      prev_hold <= hif.out_valid && !hif.out_ready;
      prev_data <= hif.out_data;
    end else begin
      prev_hold <= 1'b0;
    end
  end

  // Reference model state: the C matrix resident in the TPU as the host intends it.
  logic [15:0] c_ref [DIM][DIM];

  typedef struct {
    bit load_c;
    bit a_rand;
    int b_k;
    int in_mode;
    int out_mode;
    int stall_word;
    bit start_in_wait;
    int exp_writes;
    int exp_go;
    int exp_done;
  } vec_t;

  task automatic run_txn(input vec_t v, input int id);
    logic [7:0]  a_el [DIM][DIM];
    logic [7:0]  b_el [DIM][DIM];
    logic [15:0] c_el [DIM][DIM];
    logic [63:0] in_q[$];
    logic [15:0] exp_addr[$];
    logic [63:0] exp_w [CW];
    logic [63:0] w;
    logic [63:0] gw;
    logic [15:0] acc;
    bus_t        b;
    int bus_base, got_base, done_base, stab_base, n_in;
    int n_wr, wr_err, n_go, go_idx, n_wait, n_rd, rd_err, neu_err, i;

    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        a_el[r][c] = v.a_rand ? 8'($urandom_range(0, 255)) : ((r == c) ? 8'd1 : 8'd0);
        b_el[r][c] = (v.b_k == 0) ? 8'($urandom_range(0, 255)) : ((r == c) ? 8'(v.b_k) : 8'd0);
        c_el[r][c] = v.a_rand ? 16'($urandom_range(0, 65535)) : 16'd0;
      end
    for (int k = 0; k < DIM; k++) begin
      for (int e = 0; e < DIM; e++) w[8*e +: 8] = a_el[k][e];
      in_q.push_back(w);
      exp_addr.push_back(16'h0100 + 16'(8 * k));
    end
    for (int k = 0; k < DIM; k++) begin
      for (int e = 0; e < DIM; e++) w[8*e +: 8] = b_el[k][e];
      in_q.push_back(w);
      exp_addr.push_back(16'h0200 + 16'(8 * k));
    end
    if (v.load_c)
      for (int j = 0; j < CW; j++) begin
        for (int e = 0; e < 4; e++) w[16*e +: 16] = c_el[j / 2][4 * (j % 2) + e];
        in_q.push_back(w);
        exp_addr.push_back(16'h0300 + 16'(8 * j));
      end
    n_in = in_q.size();

    if (v.load_c)
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) c_ref[r][c] = c_el[r][c];
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        acc = c_ref[r][c];
        for (int m = 0; m < DIM; m++) acc = acc + 16'(a_el[r][m]) * 16'(b_el[m][c]);
        c_ref[r][c] = acc;
      end
    for (int j = 0; j < CW; j++)
      for (int e = 0; e < 4; e++) exp_w[j][16*e +: 16] = c_ref[j / 2][4 * (j % 2) + e];

    bus_base  = bus_q.size();
    got_base  = got_q.size();
    done_base = done_cnt;
    stab_base = stab_err;

    @(posedge clk); #1;
    hif.start      = 1'b1;
    hif.cfg_load_c = v.load_c;
    @(posedge clk); #1;
    hif.start = 1'b0;

    fork
      begin : in_driver
        int cyc, k;
        logic hs;
        cyc = 0;
        k = 0;
        while (k < n_in && cyc < 2000) begin
          case (v.in_mode)
            1:       hif.in_valid = (cyc % 2 == 0);
            2:       hif.in_valid = 1'($urandom_range(0, 1));
            default: hif.in_valid = 1'b1;
          endcase
          hif.in_data = hif.in_valid ? in_q[k] : {$urandom, $urandom};
          @(negedge clk);
          hs = hif.in_valid && hif.in_ready;
          @(posedge clk); #1;
          if (hs) k++;
          cyc++;
        end
        hif.in_valid = 1'b0;
        if (k < n_in) check_int($sformatf("t%0d_in_timeout", id), k, n_in);
        if (v.start_in_wait) begin
          repeat (5) @(posedge clk);
          #1 hif.start = 1'b1;
          @(posedge clk); #1;
          hif.start = 1'b0;
        end
      end
      begin : out_driver
        int cyc, stall;
        cyc = 0;
        stall = 5;
        while (done_cnt == done_base && cyc < 3000) begin
          if (v.out_mode == 1 && hif.out_valid && (got_q.size() - got_base) == v.stall_word && stall > 0) begin
            hif.out_ready = 1'b0;
            stall--;
          end else if (v.out_mode == 2) begin
            hif.out_ready = 1'($urandom_range(0, 1));
          end else begin
            hif.out_ready = 1'b1;
          end
          @(posedge clk); #1;
          cyc++;
        end
      end
    join
    hif.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    check_int($sformatf("t%0d_done_count", id), done_cnt - done_base, v.exp_done);
    check_int($sformatf("t%0d_word_count", id), got_q.size() - got_base, CW);
    for (int j = 0; j < CW; j++) begin
      gw = (got_base + j < got_q.size()) ? got_q[got_base + j] : 64'hx;
      check($sformatf("t%0d_word%0d", id, j), gw, exp_w[j]);
    end

    n_wr = 0; wr_err = 0; n_go = 0; go_idx = -1; n_rd = 0; rd_err = 0; neu_err = 0;
    for (int k = bus_base; k < bus_q.size(); k++) begin
      b = bus_q[k];
      if (b.rw && b.addr == 16'h0400) begin
        n_go++;
        if (go_idx < 0) go_idx = k;
        if (b.wdata != '0) neu_err++;
      end else if (b.rw) begin
        if (n_wr >= n_in || go_idx >= 0 || b.addr != exp_addr[n_wr] || b.wdata != in_q[n_wr]) wr_err++;
        n_wr++;
      end else begin
        if (b.wdata != '0 || b.addr == 16'h0400) neu_err++;
        else if (b.addr != 16'h0000) begin
          if (b.addr != 16'h0300 + 16'(8 * n_rd)) rd_err++;
          n_rd++;
        end
      end
    end
    n_wait = 0;
    if (go_idx >= 0) begin
      i = go_idx + 1;
      while (i < bus_q.size() && !bus_q[i].rw && bus_q[i].addr == 16'h0000) begin
        n_wait++;
        i++;
      end
    end
    check_int($sformatf("t%0d_write_count", id), n_wr, v.exp_writes);
    check_int($sformatf("t%0d_write_seq_err", id), wr_err, 0);
    check_int($sformatf("t%0d_go_count", id), n_go, v.exp_go);
    check_int($sformatf("t%0d_wait_cycles", id), n_wait, MUL_WAIT);
    check_int($sformatf("t%0d_read_count", id), n_rd, CW);
    check_int($sformatf("t%0d_read_seq_err", id), rd_err, 0);
    check_int($sformatf("t%0d_neutral_err", id), neu_err, 0);
    check_int($sformatf("t%0d_out_stable_err", id), stab_err - stab_base, 0);
    check($sformatf("t%0d_busy_idle", id), 64'(hif.busy), 64'd0);
  endtask

  vec_t vecs [7];

  initial begin
    int err;

    vecs[0] = '{load_c:1, a_rand:0, b_k:3, in_mode:0, out_mode:0, stall_word:0, start_in_wait:0, exp_writes:32, exp_go:1, exp_done:1};
    vecs[1] = '{load_c:1, a_rand:0, b_k:3, in_mode:1, out_mode:0, stall_word:0, start_in_wait:0, exp_writes:32, exp_go:1, exp_done:1};
    vecs[2] = '{load_c:1, a_rand:0, b_k:3, in_mode:0, out_mode:1, stall_word:3, start_in_wait:0, exp_writes:32, exp_go:1, exp_done:1};
    vecs[3] = '{load_c:0, a_rand:0, b_k:3, in_mode:0, out_mode:0, stall_word:0, start_in_wait:1, exp_writes:16, exp_go:1, exp_done:1};
    vecs[4] = '{load_c:1, a_rand:1, b_k:0, in_mode:2, out_mode:2, stall_word:0, start_in_wait:0, exp_writes:32, exp_go:1, exp_done:1};
    vecs[5] = '{load_c:0, a_rand:1, b_k:0, in_mode:2, out_mode:2, stall_word:0, start_in_wait:1, exp_writes:16, exp_go:1, exp_done:1};
    vecs[6] = '{load_c:1, a_rand:0, b_k:7, in_mode:1, out_mode:1, stall_word:15, start_in_wait:0, exp_writes:32, exp_go:1, exp_done:1};

    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) c_ref[r][c] = '0;

    hif.start = 1'b0;
    hif.cfg_load_c = 1'b0;
    hif.in_valid = 1'b0;
    hif.in_data = '0;
    hif.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(hif.busy), 64'd0);
    check("rst_in_ready", 64'(hif.in_ready), 64'd0);
    check("rst_out_valid", 64'(hif.out_valid), 64'd0);
    check("rst_out_data", hif.out_data, 64'd0);
    check("rst_done", 64'(hif.done), 64'd0);
    check("rst_r_w", 64'(hif.tpu_r_w), 64'd0);
    check("rst_addr", 64'(hif.tpu_addr), 64'd0);
    check("rst_wdata", hif.tpu_wdata, 64'd0);
    rst_n = 1'b1;

    // Reset asserted in the middle of the B window.
    @(posedge clk); #1;
    hif.start = 1'b1;
    hif.cfg_load_c = 1'b1;
    @(posedge clk); #1;
    hif.start = 1'b0;
    hif.in_valid = 1'b1;
    for (int k = 0; k < 11; k++) begin
      hif.in_data = 64'(k + 1);
      @(posedge clk); #1;
    end
    check("midb_busy_before", 64'(hif.busy), 64'd1);
    check("midb_addr_before", 64'(hif.tpu_addr), 64'h0210);
    rst_n = 1'b0;
    hif.in_valid = 1'b0;
    #1;
    check("midb_rst_busy", 64'(hif.busy), 64'd0);
    check("midb_rst_in_ready", 64'(hif.in_ready), 64'd0);
    check("midb_rst_addr", 64'(hif.tpu_addr), 64'd0);
    check("midb_rst_r_w", 64'(hif.tpu_r_w), 64'd0);
    check("midb_rst_wdata", hif.tpu_wdata, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    err = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (hif.tpu_addr != 16'h0000 || hif.tpu_r_w || hif.busy) err++;
    end
    check_int("post_rst_idle_err", err, 0);

    for (int t = 0; t < 7; t++) run_txn(vecs[t], t);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
